// File: rtl/spi_controller_if.sv
// Command and status bundle between the config sequencer and spi_controller.
// Handshake: a command transfers on the rising clk edge where cmd_valid && cmd_ready; the
// sequencer holds cmd_write/cmd_addr/cmd_data stable while cmd_valid is high and not yet taken.
interface spi_controller_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       busy;
  logic       done;
  logic [7:0] rd_data;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_data,
    input  cmd_ready, busy, done, rd_data
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_data,
    output cmd_ready, busy, done, rd_data
  );
endinterface

// File: rtl/spi_controller.sv
// SPI mode-0 initiator: serialises 16-bit {write, addr, data} frames MSB first and
// captures the last 8 CIPO bits of each frame into rd_data.
module spi_controller #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 4
) (
  input  logic            clk,
  input  logic            rst,
  spi_controller_if.slave bus,
  output logic            o_ncs,
  output logic            o_sclk,
  output logic            o_copi,
  input  logic            i_cipo,
  output logic [2:0]      o_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  localparam logic [7:0] L_DIV   = 8'(CLK_DIV - 1);
  localparam logic [7:0] L_SETUP = 8'(CS_SETUP - 1);
  localparam logic [7:0] L_HOLD  = 8'(CS_HOLD - 1);
  localparam logic [7:0] L_GAP   = 8'(CS_GAP - 1);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_cnt;
  logic [3:0]  r_bit;
  logic        r_phase;
  logic [15:0] r_shift;
  logic [7:0]  r_cap;
  logic [7:0]  r_rd_data;
  logic        r_done;
  logic        w_ready;
  logic        w_accept;
  logic        w_cnt_zero;
  logic [15:0] w_frame;

  assign w_cnt_zero = (r_cnt == 8'd0);
  assign w_accept   = bus.cmd_valid && w_ready;
  assign w_frame    = {bus.cmd_write, bus.cmd_addr, bus.cmd_data};

  assign bus.cmd_ready = w_ready;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = r_done;
  assign bus.rd_data   = r_rd_data;
  assign o_state       = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // The final GAP cycle can take the next command so back-to-back frames keep nCS high for exactly CS_GAP cycles.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.cmd_valid) w_next = S_SETUP;
      S_SETUP: if (w_cnt_zero) w_next = S_SHIFT;
      S_SHIFT: if (w_cnt_zero && r_phase && (r_bit == 4'd0)) w_next = S_HOLD;
      S_HOLD:  if (w_cnt_zero) w_next = S_GAP;
      S_GAP:   if (w_cnt_zero) w_next = bus.cmd_valid ? S_SETUP : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_ready = 1'b0;
    o_ncs   = 1'b1;
    o_sclk  = 1'b0;
    o_copi  = 1'b0;
    case (r_state)
      S_IDLE:  w_ready = 1'b1;
      S_SETUP: begin
        o_ncs  = 1'b0;
        o_copi = r_shift[15];
      end
      S_SHIFT: begin
        o_ncs  = 1'b0;
        o_sclk = r_phase;
        o_copi = r_shift[15];
      end
      S_HOLD: begin
        o_ncs  = 1'b0;
        o_copi = r_shift[15];
      end
      S_GAP:   w_ready = w_cnt_zero;
      default: w_ready = 1'b0;
    endcase
  end

  // r_phase: 0 = SCLK low half, 1 = SCLK high half. COPI advances only when a new low half starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= 8'd0;
      r_bit     <= 4'd0;
      r_phase   <= 1'b0;
      r_shift   <= 16'd0;
      r_cap     <= 8'd0;
      r_rd_data <= 8'd0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt   <= L_SETUP;
            r_shift <= w_frame;
          end
        end
        S_SETUP: begin
          if (w_cnt_zero) begin
            r_cnt   <= L_DIV;
            r_phase <= 1'b0;
            r_bit   <= 4'd15;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_SHIFT: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - 8'd1;
          end else if (!r_phase) begin
            r_phase <= 1'b1;
            r_cnt   <= L_DIV;
            r_cap   <= {r_cap[6:0], i_cipo};
          end else if (r_bit != 4'd0) begin
            r_phase <= 1'b0;
            r_bit   <= r_bit - 4'd1;
            r_shift <= {r_shift[14:0], 1'b0};
            r_cnt   <= L_DIV;
          end else begin
            r_cnt <= L_HOLD;
          end
        end
        S_HOLD: begin
          if (w_cnt_zero) r_cnt <= L_GAP;
          else            r_cnt <= r_cnt - 8'd1;
        end
        S_GAP: begin
          if (w_cnt_zero) begin
            r_rd_data <= r_cap;
            r_done    <= 1'b1;
            if (w_accept) begin
              r_cnt   <= L_SETUP;
              r_shift <= w_frame;
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: r_cnt <= 8'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: two instances (default timing and the fastest legal timing)
// driven with directed and random frames; a pin monitor compares each frame with a queued model.
module tb_spi_controller;

  localparam int DIV_A = 4, SETUP_A = 2, HOLD_A = 2, GAP_A = 4;
  localparam int DIV_B = 1, SETUP_B = 1, HOLD_B = 1, GAP_B = 1;

  typedef struct {
    int          d;
    logic [15:0] frame;
    logic [15:0] cipo;
    longint      e0;
    bit          chk_gap;
    bit          abort;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic   clk;
  logic   rst;
  longint cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  spi_controller_if ifa();
  spi_controller_if ifb();

  logic       a_ncs, a_sclk, a_copi, a_cipo;
  logic       b_ncs, b_sclk, b_copi, b_cipo;
  logic [2:0] a_state, b_state;

  spi_controller #(.CLK_DIV(DIV_A), .CS_SETUP(SETUP_A), .CS_HOLD(HOLD_A), .CS_GAP(GAP_A)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa), .o_ncs(a_ncs), .o_sclk(a_sclk), .o_copi(a_copi),
    .i_cipo(a_cipo), .o_state(a_state)
  );

  spi_controller #(.CLK_DIV(DIV_B), .CS_SETUP(SETUP_B), .CS_HOLD(HOLD_B), .CS_GAP(GAP_B)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb), .o_ncs(b_ncs), .o_sclk(b_sclk), .o_copi(b_copi),
    .i_cipo(b_cipo), .o_state(b_state)
  );

  logic       ncs_w[2], sclk_w[2], copi_w[2], ready_w[2], busy_w[2], done_w[2];
  logic [7:0] rd_w[2];
  logic       cipo_r[2];

  assign ncs_w[0] = a_ncs;           assign ncs_w[1] = b_ncs;
  assign sclk_w[0] = a_sclk;         assign sclk_w[1] = b_sclk;
  assign copi_w[0] = a_copi;         assign copi_w[1] = b_copi;
  assign ready_w[0] = ifa.cmd_ready; assign ready_w[1] = ifb.cmd_ready;
  assign busy_w[0] = ifa.busy;       assign busy_w[1] = ifb.busy;
  assign done_w[0] = ifa.done;       assign done_w[1] = ifb.done;
  assign rd_w[0] = ifa.rd_data;      assign rd_w[1] = ifb.rd_data;
  assign a_cipo = cipo_r[0];
  assign b_cipo = cipo_r[1];

  // ---------------- reference model ----------------
  function automatic int t_div(input int d);   return (d == 0) ? DIV_A : DIV_B;     endfunction
  function automatic int t_setup(input int d); return (d == 0) ? SETUP_A : SETUP_B; endfunction
  function automatic int t_hold(input int d);  return (d == 0) ? HOLD_A : HOLD_B;   endfunction
  function automatic int t_gap(input int d);   return (d == 0) ? GAP_A : GAP_B;     endfunction
  function automatic int ncs_low_len(input int d);
    return t_setup(d) + 32 * t_div(d) + t_hold(d);
  endfunction
  function automatic int period(input int d);
    return ncs_low_len(d) + t_gap(d);
  endfunction

  // ---------------- scoreboard ----------------
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_frames_done = 0;
  int   n_frames_exp = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, req, req, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  exp_t        cur[2];
  bit          have_cur[2];
  logic        prev_ncs[2], prev_sclk[2], hold_bit[2];
  bit          stable_ok[2], hs_ok[2];
  int          low_cnt[2], low_len[2], high_cnt[2], nrise[2], cipo_idx[2];
  logic [15:0] bits[2];
  longint      first_rise[2], last_rise[2];

  task automatic monitor();
    for (int d = 0; d < 2; d++) begin
      have_cur[d] = 0; prev_ncs[d] = 1'b1; prev_sclk[d] = 1'b0; hold_bit[d] = 1'b0;
      stable_ok[d] = 1; hs_ok[d] = 1; low_cnt[d] = 0; low_len[d] = 0; high_cnt[d] = 0;
      nrise[d] = 0; cipo_idx[d] = 15; bits[d] = 16'd0; first_rise[d] = 0; last_rise[d] = 0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (done_w[d]) begin
          if (!have_cur[d]) begin
            check("unexpected_done", 1, 0);
          end else begin
            check("done_cycle", cyc, cur[d].e0 + period(d));
            check("copi_bits", bits[d], cur[d].frame);
            check("sclk_rises", nrise[d], 16);
            check("ncs_low_cycles", low_len[d], ncs_low_len(d));
            check("first_rise_cycle", first_rise[d], cur[d].e0 + t_setup(d) + t_div(d));
            check("sclk_span", last_rise[d] - first_rise[d], 30 * t_div(d));
            check("rd_data", rd_w[d], cur[d].cipo[7:0]);
            check("copi_stable_high", stable_ok[d], 1);
            check("ready_busy_window", hs_ok[d], 1);
            have_cur[d] = 0;
            n_frames_done++;
          end
        end
        if (have_cur[d]) begin
          if (ready_w[d] != (cyc == cur[d].e0 + period(d) - 1)) hs_ok[d] = 0;
          if (!busy_w[d]) hs_ok[d] = 0;
          if (sclk_w[d] && prev_sclk[d] && (copi_w[d] != hold_bit[d])) stable_ok[d] = 0;
        end
        if (prev_ncs[d] && !ncs_w[d]) begin
          if (exp_q.size() == 0 || exp_q[0].d != d) begin
            check("unexpected_frame", 1, 0);
            have_cur[d] = 0;
          end else begin
            cur[d] = exp_q.pop_front();
            have_cur[d] = 1;
            check("ncs_fall_cycle", cyc, cur[d].e0);
            if (cur[d].chk_gap) check("ncs_gap_cycles", high_cnt[d], t_gap(d));
            low_cnt[d] = 0; nrise[d] = 0; bits[d] = 16'd0;
            stable_ok[d] = 1; hs_ok[d] = 1; cipo_idx[d] = 15;
            cipo_r[d] = cur[d].cipo[15];
          end
        end
        if (!ncs_w[d] && have_cur[d]) begin
          low_cnt[d]++;
          if (sclk_w[d] && !prev_sclk[d]) begin
            bits[d] = {bits[d][14:0], copi_w[d]};
            if (nrise[d] == 0) first_rise[d] = cyc;
            last_rise[d] = cyc;
            nrise[d]++;
            hold_bit[d] = copi_w[d];
          end else if (!sclk_w[d] && prev_sclk[d] && cipo_idx[d] > 0) begin
            cipo_idx[d]--;
            cipo_r[d] = cur[d].cipo[cipo_idx[d]];
          end
        end
        if (ncs_w[d]) begin
          if (!prev_ncs[d]) begin
            low_len[d] = low_cnt[d];
            high_cnt[d] = 1;
            if (have_cur[d] && cur[d].abort) have_cur[d] = 0;
          end else begin
            high_cnt[d]++;
          end
          cipo_r[d] = 1'b0;
        end
        prev_ncs[d] = ncs_w[d];
        prev_sclk[d] = sclk_w[d];
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_cmd(input int d, input logic v, input logic w, input logic [6:0] a,
                         input logic [7:0] dt);
    if (d == 0) begin
      ifa.cmd_valid = v; ifa.cmd_write = w; ifa.cmd_addr = a; ifa.cmd_data = dt;
    end else begin
      ifb.cmd_valid = v; ifb.cmd_write = w; ifb.cmd_addr = a; ifb.cmd_data = dt;
    end
  endtask

  task automatic send(input int d, input logic w, input logic [6:0] a, input logic [7:0] dt,
                      input logic [15:0] cipo, input bit keep, input bit chk_gap,
                      input bit abort, output longint e0);
    exp_t e;
    int   waited;
    @(negedge clk);
    set_cmd(d, 1'b1, w, a, dt);
    waited = 0;
    while (!ready_w[d] && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (!ready_w[d]) begin
      check("ready_timeout", 0, 1);
      set_cmd(d, 1'b0, w, a, dt);
      e0 = -1;
      return;
    end
    e0 = cyc + 1;
    e.d = d; e.frame = {w, a, dt}; e.cipo = cipo; e.e0 = e0;
    e.chk_gap = chk_gap; e.abort = abort;
    exp_q.push_back(e);
    if (!abort) n_frames_exp++;
    @(negedge clk);
    if (!keep) set_cmd(d, 1'b0, w, a, dt);
  endtask

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || have_cur[d]) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("drain", (exp_q.size() == 0 && !have_cur[d]), 1);
    repeat (10) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  task automatic stimulus();
    longint e0;
    bit     keep, prev_keep;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_ncs", ncs_w[d], 1);
      check("rst_sclk", sclk_w[d], 0);
      check("rst_copi", copi_w[d], 0);
      check("rst_busy", busy_w[d], 0);
      check("rst_done", done_w[d], 0);
      check("rst_rd_data", rd_w[d], 0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) check("ready_after_reset", ready_w[d], 1);

    // default write frame
    send(0, 1'b1, 7'h04, 8'h80, 16'($urandom), 0, 0, 0, e0);
    wait_idle(0);

    // read with 0xA5 returned on the data byte
    send(0, 1'b0, 7'h02, 8'($urandom_range(0, 255)), {8'($urandom_range(0, 255)), 8'hA5}, 0, 0, 0, e0);
    wait_idle(0);

    // back-to-back writes with cmd_valid held
    send(0, 1'b1, 7'h00, 8'hFF, 16'($urandom), 1, 0, 0, e0);
    send(0, 1'b1, 7'h01, 8'h3C, 16'($urandom), 0, 1, 0, e0);
    wait_idle(0);

    // one-cycle cmd_valid pulse while busy must be ignored
    send(0, 1'b1, 7'h11, 8'h22, 16'($urandom) | 16'h0001, 0, 0, 0, e0);
    repeat (20) @(negedge clk);
    check("ready_low_mid_frame", ready_w[0], 0);
    set_cmd(0, 1'b1, 1'b0, 7'h55, 8'hAA);
    @(negedge clk);
    set_cmd(0, 1'b0, 1'b0, 7'h55, 8'hAA);
    wait_idle(0);
    repeat (200) @(negedge clk);
    check("frames_after_busy_pulse", n_frames_done, n_frames_exp);

    // reset during the high half of bit 9
    send(0, 1'b1, 7'h2A, 8'($urandom_range(0, 255)), 16'($urandom), 0, 0, 1, e0);
    while (cyc < e0 + 55) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_ncs", ncs_w[0], 1);
    check("abort_sclk", sclk_w[0], 0);
    check("abort_copi", copi_w[0], 0);
    check("abort_busy", busy_w[0], 0);
    check("abort_done", done_w[0], 0);
    check("abort_rd_data", rd_w[0], 0);
    check("abort_ready", ready_w[0], 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    send(0, 1'b1, 7'h33, 8'h5A, 16'($urandom), 0, 0, 0, e0);
    wait_idle(0);

    // random traffic on both timing configurations
    prev_keep = 0;
    for (int i = 0; i < 8; i++) begin
      keep = (i < 7) ? 1'($urandom_range(0, 1)) : 1'b0;
      send(0, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)),
           16'($urandom), keep, prev_keep, 0, e0);
      prev_keep = keep;
    end
    wait_idle(0);
    prev_keep = 0;
    for (int i = 0; i < 6; i++) begin
      keep = (i < 5) ? 1'($urandom_range(0, 1)) : 1'b0;
      send(1, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)),
           16'($urandom), keep, prev_keep, 0, e0);
      prev_keep = keep;
    end
    wait_idle(1);
    check("frame_count", n_frames_done, n_frames_exp);
  endtask

  // ---------------- top-level sequencing and report ----------------
  initial begin
    rst = 1'b1;
    set_cmd(0, 1'b0, 1'b0, 7'h00, 8'h00);
    set_cmd(1, 1'b0, 1'b0, 7'h00, 8'h00);
    cipo_r[0] = 1'b0;
    cipo_r[1] = 1'b0;
    fork
      monitor();
      stimulus();
      begin
        repeat (60000) @(posedge clk);
        n_checks++;
        n_errors++;
        $display("FAIL global_timeout: still running at cycle %0d, required to end before 60000 (state a=%0d b=%0d)",
                 cyc, a_state, b_state);
      end
    join_any
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
